// File: rtl/fll_boot_pkg.sv
// Shared types for the FLL boot sequencer: FSM states, FLL register map and bus payload.
package fll_boot_pkg;

    localparam int unsigned FLL_ADDR_W = 2;
    localparam int unsigned FLL_DATA_W = 32;
    localparam int unsigned STATUS_W   = 16;

    localparam logic [FLL_ADDR_W-1:0] FLL_REG_STATUS  = FLL_ADDR_W'(0);
    localparam logic [FLL_ADDR_W-1:0] FLL_REG_CONFIG1 = FLL_ADDR_W'(1);
    localparam logic [FLL_ADDR_W-1:0] FLL_REG_CONFIG2 = FLL_ADDR_W'(2);
    localparam logic [FLL_ADDR_W-1:0] FLL_REG_INTEG   = FLL_ADDR_W'(3);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_REQ, S_WR_ACKLO, S_POLL_WAIT, S_RD_REQ, S_RD_ACKLO, S_CHECK, S_DONE, S_ERR
    } boot_state_t;

    typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_ACKLO} hs_state_t;

    typedef struct packed {
        logic                  req;
        logic                  web;
        logic [FLL_ADDR_W-1:0] addr;
        logic [FLL_DATA_W-1:0] wdata;
    } fll_req_t;

    // Unsigned 17-bit difference, folded to magnitude; cannot wrap for 16-bit operands.
    function automatic logic lock_in_tol(input logic [STATUS_W-1:0] status,
                                         input logic [STATUS_W-1:0] target,
                                         input int unsigned         tol);
        logic [STATUS_W:0] diff;
        diff = {1'b0, status} - {1'b0, target};
        if (diff[STATUS_W]) diff = ~diff + (STATUS_W+1)'(1);
        return (diff <= (STATUS_W+1)'(tol));
    endfunction

endpackage

// File: rtl/fll_boot_hs.sv
// Four-phase request/acknowledge master toward the FLL config port.
module fll_boot_hs
    import fll_boot_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  go_i,
    input  logic                  web_i,
    input  logic [FLL_ADDR_W-1:0] addr_i,
    input  logic [FLL_DATA_W-1:0] wdata_i,
    input  logic                  m_ack_i,
    input  logic [STATUS_W-1:0]   m_rdata_i,
    output fll_req_t              m_o,
    output logic                  acked_o,
    output logic                  done_o,
    output logic [STATUS_W-1:0]   rdata_o
);

    hs_state_t state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= HS_IDLE;
            m_o     <= '0;
            acked_o <= 1'b0;
            done_o  <= 1'b0;
            rdata_o <= '0;
        end else begin
            acked_o <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                HS_IDLE: if (go_i) begin
                    m_o   <= '{req: 1'b1, web: web_i, addr: addr_i, wdata: wdata_i};
                    state <= HS_REQ;
                end
                // Read data is captured on the first cycle the acknowledge is seen.
                HS_REQ: if (m_ack_i) begin
                    m_o.req <= 1'b0;
                    rdata_o <= m_rdata_i;
                    acked_o <= 1'b1;
                    state   <= HS_ACKLO;
                end
                HS_ACKLO: if (!m_ack_i) begin
                    done_o <= 1'b1;
                    state  <= HS_IDLE;
                end
                default: state <= HS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fll_boot_seq.sv
// FLL boot sequencer: writes boot config, polls STATUS for lock, then passes APB traffic through.
// Optional FLL_BOOT_TIMEOUT_EN adds a poll-phase timeout that ends in the error state.
module fll_boot_seq
    import fll_boot_pkg::*;
#(
    parameter int unsigned NUM_CFG      = 4,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned LOCK_TOL     = 16,
    parameter int unsigned POLL_GAP     = 32,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [NUM_CFG*ADDR_W-1:0] cfg_addr_i,
    input  logic [NUM_CFG*DATA_W-1:0] cfg_data_i,
    input  logic [STATUS_W-1:0]       target_i,
    input  logic                      s_req_i,
    input  logic                      s_web_i,
    input  logic [ADDR_W-1:0]         s_addr_i,
    input  logic [DATA_W-1:0]         s_wdata_i,
    output logic                      s_ack_o,
    output logic [DATA_W-1:0]         s_rdata_o,
    output logic                      m_req_o,
    output logic                      m_web_o,
    output logic [ADDR_W-1:0]         m_addr_o,
    output logic [DATA_W-1:0]         m_wdata_o,
    input  logic                      m_ack_i,
    input  logic [DATA_W-1:0]         m_rdata_i,
    output logic                      busy_o,
    output logic                      locked_o,
    output logic                      timeout_o
);

    localparam int unsigned IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CFG - 1);

    if (NUM_CFG == 0)          begin : g_bad_num_cfg  $error("fll_boot_seq: NUM_CFG must be >= 1"); end
    if (POLL_GAP == 0)         begin : g_bad_gap      $error("fll_boot_seq: POLL_GAP must be >= 1"); end
    if (LOCK_TIMEOUT == 0)     begin : g_bad_timeout  $error("fll_boot_seq: LOCK_TIMEOUT must be >= 1"); end
    if (ADDR_W != FLL_ADDR_W)  begin : g_bad_addr_w   $error("fll_boot_seq: ADDR_W must match FLL_ADDR_W"); end
    if (DATA_W != FLL_DATA_W)  begin : g_bad_data_w   $error("fll_boot_seq: DATA_W must match FLL_DATA_W"); end

    boot_state_t          state;
    logic [IDX_W-1:0]     idx;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 go_q, busy_q, locked_q, start_pend;
    logic                 tmo_hit, in_tol;
    logic                 hs_acked, hs_done;
    logic [STATUS_W-1:0]  hs_status;
    fll_req_t             hs_m;
    logic                 hs_web;
    logic [ADDR_W-1:0]    hs_addr;
    logic [DATA_W-1:0]    hs_wdata;
    logic [ADDR_W-1:0]    cfg_addr [NUM_CFG];
    logic [DATA_W-1:0]    cfg_data [NUM_CFG];

    for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
        assign cfg_addr[i] = cfg_addr_i[i*ADDR_W +: ADDR_W];
        assign cfg_data[i] = cfg_data_i[i*DATA_W +: DATA_W];
    end

    assign hs_web   = (state == S_RD_REQ);
    assign hs_addr  = hs_web ? FLL_REG_STATUS : cfg_addr[idx];
    assign hs_wdata = hs_web ? '0 : cfg_data[idx];
    assign in_tol   = lock_in_tol(hs_status, target_i, LOCK_TOL);

    fll_boot_hs u_hs (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .go_i      (go_q),
        .web_i     (hs_web),
        .addr_i    (hs_addr),
        .wdata_i   (hs_wdata),
        .m_ack_i   (m_ack_i),
        .m_rdata_i (m_rdata_i[STATUS_W-1:0]),
        .m_o       (hs_m),
        .acked_o   (hs_acked),
        .done_o    (hs_done),
        .rdata_o   (hs_status)
    );

`ifdef FLL_BOOT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_q;
    logic             poll_phase;

    assign poll_phase = (state == S_POLL_WAIT) || (state == S_RD_REQ) ||
                        (state == S_RD_ACKLO)  || (state == S_CHECK);
    assign tmo_hit    = (tmo_cnt == TMO_W'(LOCK_TIMEOUT));
    assign timeout_o  = timeout_q;

    // Poll-phase cycle counter; restarts when the last boot write completes, saturates at the limit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                              tmo_cnt <= '0;
        else if (state == S_WR_ACKLO && hs_done && idx == IDX_LAST) tmo_cnt <= '0;
        else if (poll_phase && !tmo_hit)                        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            idx        <= '0;
            gap_cnt    <= '0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            locked_q   <= 1'b0;
            start_pend <= 1'b0;
`ifdef FLL_BOOT_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            go_q <= 1'b0;
            case (state)
                // Bus is only taken over once any upstream handshake has fully closed.
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) start_pend <= 1'b1;
                    if ((start_i || start_pend) && !s_req_i && !m_ack_i) begin
                        start_pend <= 1'b0;
                        locked_q   <= 1'b0;
`ifdef FLL_BOOT_TIMEOUT_EN
                        timeout_q  <= 1'b0;
`endif
                        idx        <= '0;
                        go_q       <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= S_WR_REQ;
                    end
                end
                S_WR_REQ: if (hs_acked) state <= S_WR_ACKLO;
                S_WR_ACKLO: if (hs_done) begin
                    if (idx != IDX_LAST) begin
                        idx   <= idx + IDX_W'(1);
                        go_q  <= 1'b1;
                        state <= S_WR_REQ;
                    end else begin
                        gap_cnt <= '0;
                        state   <= S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    if (tmo_hit) begin
                        busy_q <= 1'b0;
`ifdef FLL_BOOT_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                        state  <= S_ERR;
                    end else if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                        go_q  <= 1'b1;
                        state <= S_RD_REQ;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_RD_REQ:   if (hs_acked) state <= S_RD_ACKLO;
                S_RD_ACKLO: if (hs_done)  state <= S_CHECK;
                S_CHECK: begin
                    if (in_tol) begin
                        locked_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= S_DONE;
                    end else if (tmo_hit) begin
                        busy_q <= 1'b0;
`ifdef FLL_BOOT_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                        state  <= S_ERR;
                    end else begin
                        gap_cnt <= '0;
                        state   <= S_POLL_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign locked_o  = locked_q;

    // Ownership mux: sequencer drives the FLL while busy, otherwise APB passes straight through.
    assign m_req_o   = busy_q ? hs_m.req   : s_req_i;
    assign m_web_o   = busy_q ? hs_m.web   : s_web_i;
    assign m_addr_o  = busy_q ? hs_m.addr  : s_addr_i;
    assign m_wdata_o = busy_q ? hs_m.wdata : s_wdata_i;
    assign s_ack_o   = busy_q ? 1'b0 : m_ack_i;
    assign s_rdata_o = busy_q ? '0   : m_rdata_i;

endmodule

// File: tb/tb_fll_boot_seq.sv
// Directed bench for fll_boot_seq with a behavioural FLL model (random 1-8 cycle ack delay).
module tb_fll_boot_seq;
    import fll_boot_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0]  cfg_addr;
    logic [127:0] cfg_data;
    logic [15:0] target = 16'h0A73;
    logic        s_req = 1'b0, s_web = 1'b0;
    logic [1:0]  s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic        s_ack;
    logic [31:0] s_rdata;
    logic        m_req, m_web;
    logic [1:0]  m_addr;
    logic [31:0] m_wdata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        busy, locked, timeout;

    int n_checks = 0, n_fail = 0;

    int hold = 0, rd_cnt = 0, lock_at = 0;
    logic [15:0] st_bad = '0, st_good = '0;
    logic [1:0]  log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] regs[4];

    logic [1:0]  exp_addr[4];
    logic [31:0] exp_data[4];

    fll_boot_seq #(
        .NUM_CFG(4), .ADDR_W(2), .DATA_W(32), .LOCK_TOL(16), .POLL_GAP(8), .LOCK_TIMEOUT(200)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .target_i(target),
        .s_req_i(s_req), .s_web_i(s_web), .s_addr_i(s_addr), .s_wdata_i(s_wdata),
        .s_ack_o(s_ack), .s_rdata_o(s_rdata),
        .m_req_o(m_req), .m_web_o(m_web), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_ack_i(m_ack), .m_rdata_i(m_rdata),
        .busy_o(busy), .locked_o(locked), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    // FLL model: STATUS returns st_good from read number lock_at onward, st_bad before.
    always @(posedge clk) begin
        if (m_ack) begin
            if (!m_req) m_ack <= 1'b0;
        end else if (m_req) begin
            if (hold == 0) begin
                m_ack <= 1'b1;
                hold  <= int'($urandom_range(7, 0));
                if (m_web) begin
                    rd_cnt  <= rd_cnt + 1;
                    m_rdata <= (m_addr == FLL_REG_STATUS) ?
                               {16'h0, ((rd_cnt + 1) >= lock_at) ? st_good : st_bad} : regs[m_addr];
                end else begin
                    regs[m_addr] <= m_wdata;
                    log_addr.push_back(m_addr);
                    log_data.push_back(m_wdata);
                end
            end else begin
                hold <= hold - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        chk(tag, 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (s_ack !== lvl && n < 3000) begin @(negedge clk); n++; end
        chk(tag, 32'(n < 3000), 32'd1);
    endtask

    task automatic check_writes(input int base, input string tag);
        chk({tag, "_nwr"}, 32'(log_addr.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_addr%0d", tag, k), 32'(log_addr[base+k]), 32'(exp_addr[k]));
            chk($sformatf("%s_data%0d", tag, k), log_data[base+k], exp_data[k]);
        end
    endtask

    initial begin
        int base, rd0, n;
        exp_addr = '{FLL_REG_CONFIG1, FLL_REG_CONFIG2, FLL_REG_INTEG, FLL_REG_CONFIG1};
        exp_data = '{32'h1003_0A73, 32'h0000_0100, 32'h0000_0000, 32'h1003_0A74};
        cfg_addr = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
        cfg_data = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};

        tick(3);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_locked",  32'(locked),  32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_m_req",   32'(m_req),   32'd0);
        chk("rst_s_ack",   32'(s_ack),   32'd0);
        rst = 1'b0;
        tick(2);

        // Boot writes, then lock on the fourth poll
        st_bad = 16'h0A60; st_good = 16'h0A73; lock_at = rd_cnt + 4;
        base = log_addr.size(); rd0 = rd_cnt;
        pulse_start();
        chk("a_busy", 32'(busy), 32'd1);
        wait_idle("a_done");
        chk("a_locked",  32'(locked),  32'd1);
        chk("a_timeout", 32'(timeout), 32'd0);
        chk("a_polls",   32'(rd_cnt - rd0), 32'd4);
        check_writes(base, "a");

        // +17 keeps polling, +16 locks
        st_bad = 16'h0A84; st_good = 16'h0A83; lock_at = rd_cnt + 3; rd0 = rd_cnt;
        pulse_start();
        chk("b_locked_clr", 32'(locked), 32'd0);
        wait_idle("b_done");
        chk("b_locked", 32'(locked), 32'd1);
        chk("b_polls",  32'(rd_cnt - rd0), 32'd3);

        // -17 keeps polling, -16 locks
        st_bad = 16'h0A62; st_good = 16'h0A63; lock_at = rd_cnt + 2; rd0 = rd_cnt;
        pulse_start();
        wait_idle("c_done");
        chk("c_locked", 32'(locked), 32'd1);
        chk("c_polls",  32'(rd_cnt - rd0), 32'd2);

        // APB read of STATUS stalls while busy, served after DONE
        st_bad = 16'h0A70; st_good = 16'h0A70; lock_at = rd_cnt + 1;
        pulse_start();
        tick(2);
        s_req = 1'b1; s_web = 1'b1; s_addr = FLL_REG_STATUS;
        tick(3);
        chk("d_stall_ack",  32'(s_ack), 32'd0);
        chk("d_stall_busy", 32'(busy),  32'd1);
        wait_ack(1'b1, "d_ack_seen");
        chk("d_ack_busy",   32'(busy),   32'd0);
        chk("d_ack_locked", 32'(locked), 32'd1);
        chk("d_rdata",      s_rdata,     32'h0000_0A70);
        s_req = 1'b0;
        wait_ack(1'b0, "d_ack_drop");

        // APB write pass-through
        s_req = 1'b1; s_web = 1'b0; s_addr = FLL_REG_CONFIG2; s_wdata = 32'hDEAD_BEEF;
        wait_ack(1'b1, "p_ack_seen");
        chk("p_wr_addr", 32'(log_addr[log_addr.size()-1]), 32'(FLL_REG_CONFIG2));
        chk("p_wr_data", log_data[log_data.size()-1], 32'hDEAD_BEEF);
        s_req = 1'b0;
        wait_ack(1'b0, "p_ack_drop");

        // start_i with an upstream request pending: upstream finishes first
        lock_at = rd_cnt + 1; base = log_addr.size();
        s_req = 1'b1; s_web = 1'b0; s_addr = FLL_REG_INTEG; s_wdata = 32'h0000_0055;
        pulse_start();
        wait_ack(1'b1, "e_ack_seen");
        chk("e_busy_hold", 32'(busy), 32'd0);
        s_req = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("e_busy_after", 32'(busy), 32'd1);
        wait_idle("e_done");
        chk("e_nwr",    32'(log_addr.size() - base), 32'd5);
        chk("e_first_a", 32'(log_addr[base]),  32'(FLL_REG_INTEG));
        chk("e_first_d", log_data[base],       32'h0000_0055);
        chk("e_seq_a",  32'(log_addr[base+1]), 32'(FLL_REG_CONFIG1));
        chk("e_seq_d",  log_data[base+1],      32'h1003_0A73);

        // Reset in the middle of the first write request
        lock_at = rd_cnt + 1;
        pulse_start();
        n = 0;
        while (m_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("f_req_seen", 32'(m_req), 32'd1);
        chk("f_req_web",  32'(m_web), 32'd0);
        rst = 1'b1;
        #1;
        chk("f_rst_req",    32'(m_req),  32'd0);
        chk("f_rst_busy",   32'(busy),   32'd0);
        chk("f_rst_locked", 32'(locked), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        base = log_addr.size(); lock_at = rd_cnt + 1;
        pulse_start();
        wait_idle("f_done");
        chk("f_locked", 32'(locked), 32'd1);
        check_writes(base, "f");

`ifdef FLL_BOOT_TIMEOUT_EN
        // Never in tolerance: timeout to ERR, pass-through still live
        st_bad = 16'h0B00; lock_at = 32'h7FFF_FFFF;
        pulse_start();
        wait_idle("g_done");
        chk("g_timeout", 32'(timeout), 32'd1);
        chk("g_locked",  32'(locked),  32'd0);
        s_req = 1'b1; s_web = 1'b1; s_addr = FLL_REG_STATUS;
        wait_ack(1'b1, "g_ack_seen");
        chk("g_rdata", s_rdata, 32'h0000_0B00);
        s_req = 1'b0;
        wait_ack(1'b0, "g_ack_drop");
        st_good = 16'h0A73; lock_at = rd_cnt + 1;
        pulse_start();
        chk("g_timeout_clr", 32'(timeout), 32'd0);
        wait_idle("g_redo");
        chk("g_relock", 32'(locked), 32'd1);
`else
        // Never in tolerance: keeps polling, no timeout flag
        st_bad = 16'h0B00; lock_at = 32'h7FFF_FFFF;
        pulse_start();
        tick(400);
        chk("g_still_busy", 32'(busy),    32'd1);
        chk("g_no_timeout", 32'(timeout), 32'd0);
        rst = 1'b1;
        tick(2);
        chk("g_abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
